sequential_shift_left: RTL and testbench

- Multi-cycle arithmetic/logical left shifter for the ALU. It is the left-direction counterpart of the combinational right shifter.
- Shifts one bit per clock and produces the same 4-bit status vector layout (carry, negative, zero, overflow).
- Sits beside the ALU datapath. It is used where a single-cycle barrel shifter is too costly.
- Valid/ready handshake on both the input and result sides.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/shl_step.sv | 39 +++
 rtl/sequential_shift_left.sv | 151 +++++++++++++++
 tb/tb_sequential_shift_left.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU shift definitions: status flag indices, shifter FSM state type,
// default datapath width and a status packing helper.
package alu_pkg;

  localparam int SHL_WIDTH_DEFAULT = 32;

  // Status vector bit positions, common to all ALU shift blocks.
  localparam int ST_CARRY    = 0;
  localparam int ST_NEG      = 1;
  localparam int ST_ZERO     = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_t;

  function automatic logic [3:0] pack_status(input logic c, input logic n,
                                             input logic z, input logic v);
    logic [3:0] s;
    s              = '0;
    s[ST_CARRY]    = c;
    s[ST_NEG]      = n;
    s[ST_ZERO]     = z;
    s[ST_OVERFLOW] = v;
    return s;
  endfunction

endpackage

// File: rtl/shl_step.sv
// Combinational single-step left shifter used by sequential_shift_left.
// Shifts sreg_i left by nbits_i (0..STEP) positions, zero filling.
//   sreg_i     : current shift register value
//   nbits_i    : bits to shift this step (must not exceed STEP)
//   sign_i     : sign bit of the original operand
//   sreg_o     : shifted value
//   out_bit_o  : last bit shifted out (0 when nbits_i == 0)
//   ovf_hit_o  : any shifted-out bit or resulting MSB differs from sign_i
module shl_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] sreg_i,
  input  logic [2:0]       nbits_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] sreg_o,
  output logic             out_bit_o,
  output logic             ovf_hit_o
);

  logic [31:0] nbits32;

  assign nbits32 = 32'(nbits_i);

  always_comb begin
    sreg_o    = sreg_i;
    out_bit_o = 1'b0;
    ovf_hit_o = 1'b0;
    for (int unsigned k = 0; k < STEP; k++) begin
      if (k < nbits32) begin
        out_bit_o = sreg_o[WIDTH-1];
        if (sreg_o[WIDTH-1] != sign_i) ovf_hit_o = 1'b1;
        sreg_o = {sreg_o[WIDTH-2:0], 1'b0};
        if (sreg_o[WIDTH-1] != sign_i) ovf_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sequential_shift_left.sv
// Multi-cycle left shifter: result = operand1 << min(operand2, WIDTH),
// with carry/negative/zero/overflow status. Valid/ready on both sides.
// Optional macro SHL_STEP4_EN: advance up to 4 bits per cycle instead of 1;
// result and flags are identical, only latency changes.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = idle)
//   operand1, operand2  : value to shift, unsigned shift amount
//   out_valid/out_ready : result handshake
//   result, statusOut   : shifted value and flags (ST_* indices)
module sequential_shift_left
  import alu_pkg::*;
#(
  parameter int WIDTH = SHL_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut
);

`ifdef SHL_STEP4_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  shl_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             big_q, big_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;

  logic [CNT_W-1:0] load_cnt;
  logic [2:0]       step_n;
  logic [WIDTH-1:0] step_sreg;
  logic             step_out;
  logic             step_hit;

  assign load_cnt = (operand2 >= WIDTH_V) ? CNT_W'(WIDTH) : CNT_W'(operand2);

  always_comb begin
    if (int'(count_q) < STEP) step_n = 3'(count_q);
    else                      step_n = 3'(STEP);
  end

  shl_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .sreg_i   (sreg_q),
    .nbits_i  (step_n),
    .sign_i   (sign_q),
    .sreg_o   (step_sreg),
    .out_bit_o(step_out),
    .ovf_hit_o(step_hit)
  );

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    count_d  = count_q;
    big_d    = big_q;
    sign_d   = sign_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d  = operand1;
          sign_d  = operand1[WIDTH-1];
          big_d   = (operand2 > WIDTH_V);
          count_d = load_cnt;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          if (load_cnt == '0) begin
            // Zero shift: flags are published directly from the operand.
            state_d  = DONE;
            result_d = operand1;
            status_d = pack_status(1'b0, operand1[WIDTH-1],
                                   operand1 == '0, 1'b0);
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sreg_d  = step_sreg;
        carry_d = step_out;
        ovf_d   = ovf_q | step_hit;
        count_d = count_q - CNT_W'(step_n);
        if (count_d == '0) begin
          state_d  = DONE;
          result_d = step_sreg;
          // Shift amounts past WIDTH push out only zeros, so no carry.
          status_d = pack_status(step_out & ~big_q, step_sreg[WIDTH-1],
                                 step_sreg == '0, ovf_d);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      count_q  <= '0;
      big_q    <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      count_q  <= count_d;
      big_q    <= big_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign statusOut = status_q;

endmodule

// File: tb/tb_sequential_shift_left.sv
module tb_sequential_shift_left;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   statusOut;

  int checks = 0;
  int errors = 0;

  sequential_shift_left #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operand1 (operand1),
    .operand2 (operand2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .statusOut(statusOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: treat the shift as signed multiplication by 2^n.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [3:0] st,
                                output int lat);
    int     n;
    longint p;
    int     wide;
    logic   c, v;
    n    = (int'(b) > W) ? W : int'(b);
    p    = longint'($signed(a)) * (longint'(1) << n);
    wide = int'(a) << n;
    r    = W'(wide);
    c    = (n == 0 || int'(b) > W) ? 1'b0 : 1'(wide >> W);
    v    = (p > 127) || (p < -128);
    st   = '0;
    st[ST_CARRY]    = c;
    st[ST_NEG]      = r[W-1];
    st[ST_ZERO]     = (r == 0);
    st[ST_OVERFLOW] = v;
`ifdef SHL_STEP4_EN
    lat = (n + 3) / 4 + 1;
`else
    lat = n + 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic [3:0]   es;
    int           elat;
    int           cyc;
    model(a, b, er, es, elat);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    cyc = 1;
    while (!out_valid && cyc < 3 * W) begin
      // Busy: change operands and pulse in_valid; neither may affect the result.
      in_valid  = 1'($urandom);
      operand1  = W'($urandom);
      operand2  = W'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(elat));
    chk("result", 32'(result), 32'(er));
    chk("status", 32'(statusOut), 32'(es));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_result", 32'(result), 32'(er));
      chk("hold_status", 32'(statusOut), 32'(es));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand1  = '0;
    operand2  = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_status", 32'(statusOut), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h81, 8'd1, 0);
    run_op(8'h0F, 8'd4, 0);
    run_op(8'h80, 8'd0, 0);
    run_op(8'h01, 8'd8, 0);
    run_op(8'hFF, 8'd200, 3);
    run_op(8'h40, 8'd9, 1);
    run_op(8'h00, 8'd3, 0);

    // Reset during SHIFT aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    operand1 = 8'h5A;
    operand2 = 8'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_status", 32'(statusOut), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'hC3, 8'd6, 0);

    for (int t = 0; t < 25; t++) begin
      run_op(W'($urandom), W'($urandom_range(0, 11)), int'($urandom_range(0, 2)));
    end
    run_op(W'($urandom), W'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
